// File: rtl/led_seq_pkg.sv
// Shared types and pattern helper for the LED bar sequencer.
package led_seq_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      FILL   = 2'b00,
      DRAIN  = 2'b01,
      CHASE  = 2'b10,
      BOUNCE = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   // LED image for a mode at position p; the caller truncates to the bar width.
   function automatic logic [31:0] led_pattern(input mode_e m, input logic [31:0] p);
      logic [31:0] one;
      one = 32'd1;
      case (m)
         FILL:    return (one << (p + 32'd1)) - one;
         DRAIN:   return ~((one << p) - one);
         default: return one << p;
      endcase
   endfunction

endpackage

// File: rtl/led_bar_sequencer_if.sv
// Control/status bundle of the LED bar sequencer; carries bright when LED_BAR_DIM_EN is defined.
interface led_bar_sequencer_if #(
   parameter int unsigned N_LEDS  = 8,
   parameter int unsigned PRESC_W = 16
);
   import led_seq_pkg::*;

   localparam int unsigned POS_W = $clog2(N_LEDS);

   logic               start;
   logic               stop;
   logic               pause;
   mode_e              mode;
   logic [PRESC_W-1:0] div;
   logic               busy;
   logic               done;
   logic [POS_W-1:0]   pos;
   logic [N_LEDS-1:0]  leds;
`ifdef LED_BAR_DIM_EN
   logic [2:0]         bright;

   modport master (output start, stop, pause, mode, div, bright,
                   input  busy, done, pos, leds);
   modport slave  (input  start, stop, pause, mode, div, bright,
                   output busy, done, pos, leds);
`else
   modport master (output start, stop, pause, mode, div,
                   input  busy, done, pos, leds);
   modport slave  (input  start, stop, pause, mode, div,
                   output busy, done, pos, leds);
`endif

endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..div-1 while enabled and pulses tick on the last count.
module led_tick_gen #(
   parameter int unsigned PRESC_W = 16
) (
   input  logic               ck,
   input  logic               rs,
   input  logic               clr,
   input  logic               en,
   input  logic [PRESC_W-1:0] div,
   output logic               tick
);

   logic [PRESC_W-1:0] r_cnt;
   logic               w_last;

   // div is already normalised to >= 1 by the caller
   assign w_last = (r_cnt == (div - PRESC_W'(1)));
   assign tick   = en && w_last;

   always_ff @(posedge ck) begin
      if (rs) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_last ? '0 : r_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/led_bar_sequencer.sv
// LED bar sequencer: IDLE/RUN/PAUSE control, prescaled stepping and per-mode LED patterns.
// Optional PWM dimming via bright[2:0] when LED_BAR_DIM_EN is defined.
module led_bar_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned N_LEDS  = 8,
   parameter int unsigned PRESC_W = 16
) (
   input logic                 ck,
   input logic                 rs,
   led_bar_sequencer_if.slave  bus
);

   localparam int unsigned      POS_W    = $clog2(N_LEDS);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
   localparam logic [POS_W-1:0] POS_PREV = POS_W'(N_LEDS - 2);

   state_e             r_state, w_state_nxt;
   mode_e              r_mode;
   logic [PRESC_W-1:0] r_div;
   logic [POS_W-1:0]   r_pos, w_pos_nxt, w_step_pos;
   logic [N_LEDS-1:0]  r_leds, w_leds_nxt;
   logic               r_dir, w_dir_nxt, w_step_dir;
   logic               r_done, w_done_nxt;
   logic               r_busy;
   logic               w_tick, w_run_en, w_start_ok, w_finish, w_clr;

   // The cycle carrying done never accepts a new start.
   assign w_start_ok = (r_state == IDLE) && bus.start && !bus.stop && !r_done;
   assign w_run_en   = (r_state == RUN) && !bus.stop && !bus.pause;
   assign w_clr      = (r_state == IDLE) || bus.stop;
   assign w_finish   = w_tick && (r_pos == POS_LAST) && ((r_mode == FILL) || (r_mode == DRAIN));

   led_tick_gen #(.PRESC_W(PRESC_W)) u_tick (
      .ck   (ck),
      .rs   (rs),
      .clr  (w_clr),
      .en   (w_run_en),
      .div  (r_div),
      .tick (w_tick)
   );

   always_ff @(posedge ck) begin
      if (rs) r_state <= IDLE;
      else    r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start_ok) w_state_nxt = RUN;
         RUN: begin
            if (bus.stop)       w_state_nxt = IDLE;
            else if (bus.pause) w_state_nxt = PAUSE;
            else if (w_finish)  w_state_nxt = IDLE;
         end
         PAUSE: begin
            if (bus.stop)        w_state_nxt = IDLE;
            else if (!bus.pause) w_state_nxt = RUN;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_pos_nxt  = r_pos;
      w_leds_nxt = r_leds;
      w_dir_nxt  = r_dir;
      w_done_nxt = 1'b0;
      w_step_pos = r_pos + POS_W'(1);
      w_step_dir = r_dir;

      // BOUNCE turns at the ends so each endpoint is shown for a single step
      case (r_mode)
         CHASE:  if (r_pos == POS_LAST) w_step_pos = '0;
         BOUNCE: begin
            if (r_dir) begin
               if (r_pos == POS_LAST) begin
                  w_step_pos = POS_PREV;
                  w_step_dir = 1'b0;
               end
            end else if (r_pos == '0) begin
               w_step_pos = POS_W'(1);
               w_step_dir = 1'b1;
            end else begin
               w_step_pos = r_pos - POS_W'(1);
            end
         end
         default: ;
      endcase

      case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_pos_nxt  = '0;
               w_dir_nxt  = 1'b1;
               w_leds_nxt = N_LEDS'(led_pattern(bus.mode, 32'd0));
            end
         end
         RUN, PAUSE: begin
            if (bus.stop) begin
               w_pos_nxt  = '0;
               w_dir_nxt  = 1'b1;
               w_leds_nxt = '0;
            end else if (w_finish) begin
               w_done_nxt = 1'b1;
            end else if (w_tick) begin
               w_pos_nxt  = w_step_pos;
               w_dir_nxt  = w_step_dir;
               w_leds_nxt = N_LEDS'(led_pattern(r_mode, 32'(w_step_pos)));
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge ck) begin
      if (rs) begin
         r_pos  <= '0;
         r_leds <= '0;
         r_dir  <= 1'b1;
         r_done <= 1'b0;
         r_busy <= 1'b0;
         r_mode <= FILL;
         r_div  <= PRESC_W'(1);
      end else begin
         r_pos  <= w_pos_nxt;
         r_leds <= w_leds_nxt;
         r_dir  <= w_dir_nxt;
         r_done <= w_done_nxt;
         r_busy <= (w_state_nxt != IDLE);
         if (w_start_ok) begin
            r_mode <= bus.mode;
            r_div  <= (bus.div == '0) ? PRESC_W'(1) : bus.div;
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.pos  = r_pos;

`ifdef LED_BAR_DIM_EN
   logic [2:0] r_pwm;
   logic       w_pwm_on;

   always_ff @(posedge ck) begin
      if (rs) r_pwm <= '0;
      else    r_pwm <= r_pwm + 3'd1;
   end

   // bright=7 keeps the bar lit every cycle, bright=0 on one cycle in eight
   assign w_pwm_on = ({1'b0, r_pwm} < ({1'b0, bus.bright} + 4'd1));
   assign bus.leds = r_leds & {N_LEDS{w_pwm_on}};
`else
   assign bus.leds = r_leds;
`endif

endmodule
